// File: rtl/bp_hard_mem_pkg.sv
// ---------------------------------------------------------------------------
// Module : bp_hard_mem_pkg
// Brief  : Shared mask-mode constants, FSM state type and sizing helpers for
//          the 1RW hard-memory wrapper.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_hard_mem_pkg;

    localparam int e_mask_none = 0;
    localparam int e_mask_bit  = 1;
    localparam int e_mask_byte = 2;

    typedef enum logic [1:0] {
        e_state_reset = 2'd0,
        e_state_init  = 2'd1,
        e_state_ready = 2'd2
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int mask_width(input int width, input int mode);
        case (mode)
            e_mask_bit:  return width;
            e_mask_byte: return width / 8;
            default:     return 1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_hard_mem_1rw_init_wrapper_if.sv
// ---------------------------------------------------------------------------
// Module : bp_hard_mem_1rw_init_wrapper_if
// Brief  : Request/response bundle between a cache engine and the wrapper.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bp_hard_mem_1rw_init_wrapper_if #(
    parameter int width_p      = 64,
    parameter int addr_width_p = 9,
    parameter int mask_width_p = 1
);
    logic                    v_i;
    logic                    w_i;
    logic [addr_width_p-1:0] addr_i;
    logic [width_p-1:0]      data_i;
    logic [mask_width_p-1:0] w_mask_i;
    logic                    ready_o;
    logic                    v_o;
    logic [width_p-1:0]      data_o;

    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i,
        output ready_o, v_o, data_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_hard_mem_mask_expand.sv
// ---------------------------------------------------------------------------
// Module : bp_hard_mem_mask_expand
// Brief  : Combinational expansion of a none/bit/byte write mask to a
//          full-width bit mask.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_hard_mem_mask_expand
    import bp_hard_mem_pkg::*;
#(
    parameter int  width_p       = 64,
    parameter int  mask_mode_p   = 0,
    localparam int mask_width_lp = mask_width(width_p, mask_mode_p)
) (
    input  logic [mask_width_lp-1:0] i_mask,
    output logic [width_p-1:0]       o_mask
);

    generate
        if (mask_mode_p == e_mask_bit) begin : g_bit
            assign o_mask = i_mask;
        end else if (mask_mode_p == e_mask_byte) begin : g_byte
            for (genvar k = 0; k < width_p / 8; k++) begin : g_lane
                assign o_mask[8*k +: 8] = {8{i_mask[k]}};
            end
        end else begin : g_none
            logic w_unused_mask;
            assign w_unused_mask = ^i_mask;
            assign o_mask        = '1;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/la_spram.sv
// ---------------------------------------------------------------------------
// Module : la_spram
// Brief  : Behavioural single-port RAM with bit write mask and registered read.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module la_spram #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter     PROP  = "",
    parameter int CTRLW = 128,
    parameter int TESTW = 128
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [DW-1:0]    wmask,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic          w_unused;

    assign w_unused = ^{vss, vdd, vddio, ctrl, test};

    always_ff @(posedge clk) begin
        if (ce & we) begin
            r_mem[addr] <= (r_mem[addr] & ~wmask) | (din & wmask);
        end
        if (ce & ~we) begin
            dout <= r_mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_hard_mem_1rw_init_wrapper.sv
// ---------------------------------------------------------------------------
// Module : bp_hard_mem_1rw_init_wrapper
// Brief  : Parametrised 1RW hard-memory wrapper with init sweep, read-valid
//          strobe and read-data hold register around la_spram.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_hard_mem_1rw_init_wrapper
    import bp_hard_mem_pkg::*;
#(
    parameter int                 width_p     = 64,
    parameter int                 els_p       = 512,
    parameter int                 mask_mode_p = 0,
    parameter bit                 init_en_p   = 1'b1,
    parameter logic [width_p-1:0] init_val_p  = '0,
    localparam int                addr_width_lp = clog2_min1(els_p)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic init_i,
    bp_hard_mem_1rw_init_wrapper_if.slave bus
);

    localparam logic [addr_width_lp:0]   c_els       = (addr_width_lp+1)'(els_p);
    localparam logic [addr_width_lp-1:0] c_last_addr = addr_width_lp'(els_p - 1);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [addr_width_lp-1:0] r_init_cnt;
    logic                     r_v_o;
    logic                     r_oor;
    logic [width_p-1:0]       r_hold;

    logic                     w_in_range;
    logic                     w_rd_accept;
    logic [width_p-1:0]       w_user_mask;
    logic [width_p-1:0]       w_rd_data;
    logic                     w_ram_ce;
    logic                     w_ram_we;
    logic [addr_width_lp-1:0] w_ram_addr;
    logic [width_p-1:0]       w_ram_din;
    logic [width_p-1:0]       w_ram_wmask;
    logic [width_p-1:0]       w_ram_dout;

    bp_hard_mem_mask_expand #(
        .width_p     (width_p),
        .mask_mode_p (mask_mode_p)
    ) u_mask_expand (
        .i_mask (bus.w_mask_i),
        .o_mask (w_user_mask)
    );

    assign w_in_range  = ({1'b0, bus.addr_i} < c_els);
    assign bus.ready_o = (r_state == e_state_ready);
    // init_i has priority: a request arriving with it is dropped.
    assign w_rd_accept = bus.v_i & bus.ready_o & ~init_i & ~bus.w_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_state_reset;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ram_ce     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = bus.addr_i;
        w_ram_din    = bus.data_i;
        w_ram_wmask  = w_user_mask;
        case (r_state)
            e_state_reset: begin
                w_state_next = init_en_p ? e_state_init : e_state_ready;
            end
            e_state_init: begin
                w_ram_ce    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_init_cnt;
                w_ram_din   = init_val_p;
                w_ram_wmask = '1;
                if (r_init_cnt == c_last_addr) begin
                    w_state_next = e_state_ready;
                end
            end
            e_state_ready: begin
                if (init_i) begin
                    w_state_next = e_state_init;
                end else if (bus.v_i & w_in_range) begin
                    w_ram_ce = 1'b1;
                    w_ram_we = bus.w_i;
                end
            end
            default: begin
                w_state_next = e_state_reset;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_init_cnt <= '0;
        end else if ((r_state == e_state_init) && (r_init_cnt != c_last_addr)) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end else begin
            r_init_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v_o  <= 1'b0;
            r_oor  <= 1'b0;
            r_hold <= '0;
        end else begin
            r_v_o <= w_rd_accept;
            if (w_rd_accept) begin
                r_oor <= ~w_in_range;
            end
            if (r_v_o) begin
                r_hold <= w_rd_data;
            end
        end
    end

    // Out-of-range reads never touch the RAM, so their data is forced to zero.
    assign w_rd_data   = r_oor ? '0 : w_ram_dout;
    assign bus.v_o     = r_v_o;
    assign bus.data_o  = r_v_o ? w_rd_data : r_hold;

    la_spram #(
        .DW (width_p),
        .AW (addr_width_lp)
    ) u_spram (
        .clk   (clk_i),
        .ce    (w_ram_ce),
        .we    (w_ram_we),
        .wmask (w_ram_wmask),
        .addr  (w_ram_addr),
        .din   (w_ram_din),
        .dout  (w_ram_dout),
        .vss   (1'b0),
        .vdd   (1'b1),
        .vddio (1'b1),
        .ctrl  ('0),
        .test  ('0)
    );

endmodule

`default_nettype wire

// File: tb/tb_bp_hard_mem_1rw_init_wrapper.sv
// ---------------------------------------------------------------------------
// Module : tb_bp_hard_mem_1rw_init_wrapper
// Brief  : Directed self-checking bench over three wrapper geometries.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bp_hard_mem_1rw_init_wrapper;
    import bp_hard_mem_pkg::*;

    localparam logic [95:0] c_init_b = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic init_a = 1'b0;
    logic init_b = 1'b0;
    logic init_c = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bp_hard_mem_1rw_init_wrapper_if #(.width_p(64), .addr_width_p(9), .mask_width_p(8))  if_a ();
    bp_hard_mem_1rw_init_wrapper_if #(.width_p(96), .addr_width_p(7), .mask_width_p(96)) if_b ();
    bp_hard_mem_1rw_init_wrapper_if #(.width_p(16), .addr_width_p(3), .mask_width_p(1))  if_c ();

    bp_hard_mem_1rw_init_wrapper #(
        .width_p(64), .els_p(512), .mask_mode_p(e_mask_byte), .init_en_p(1'b1), .init_val_p(64'h0)
    ) u_dut_a (.clk_i(clk), .reset_n_i(rst_n), .init_i(init_a), .bus(if_a));

    bp_hard_mem_1rw_init_wrapper #(
        .width_p(96), .els_p(95), .mask_mode_p(e_mask_bit), .init_en_p(1'b1), .init_val_p(c_init_b)
    ) u_dut_b (.clk_i(clk), .reset_n_i(rst_n), .init_i(init_b), .bus(if_b));

    bp_hard_mem_1rw_init_wrapper #(
        .width_p(16), .els_p(8), .mask_mode_p(e_mask_none), .init_en_p(1'b0), .init_val_p(16'h0)
    ) u_dut_c (.clk_i(clk), .reset_n_i(rst_n), .init_i(init_c), .bus(if_c));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_a(input logic [8:0] addr, input logic [63:0] data, input logic [7:0] mask);
        if_a.v_i = 1'b1; if_a.w_i = 1'b1; if_a.addr_i = addr; if_a.data_i = data; if_a.w_mask_i = mask;
        @(negedge clk);
        if_a.v_i = 1'b0;
        check("a.wr_no_v", if_a.v_o, 0);
    endtask

    task automatic rd_a(input string tag, input logic [8:0] addr, input logic [63:0] exp);
        if_a.v_i = 1'b1; if_a.w_i = 1'b0; if_a.addr_i = addr;
        @(negedge clk);
        if_a.v_i = 1'b0;
        check({tag, ".v"}, if_a.v_o, 1);
        check(tag, if_a.data_o, exp);
    endtask

    task automatic wr_b(input logic [6:0] addr, input logic [95:0] data, input logic [95:0] mask);
        if_b.v_i = 1'b1; if_b.w_i = 1'b1; if_b.addr_i = addr; if_b.data_i = data; if_b.w_mask_i = mask;
        @(negedge clk);
        if_b.v_i = 1'b0;
        check("b.wr_no_v", if_b.v_o, 0);
    endtask

    task automatic rd_b(input string tag, input logic [6:0] addr, input logic [95:0] exp);
        if_b.v_i = 1'b1; if_b.w_i = 1'b0; if_b.addr_i = addr;
        @(negedge clk);
        if_b.v_i = 1'b0;
        check({tag, ".v"}, if_b.v_o, 1);
        check(tag, if_b.data_o, exp);
    endtask

    task automatic wr_c(input logic [2:0] addr, input logic [15:0] data, input logic mask);
        if_c.v_i = 1'b1; if_c.w_i = 1'b1; if_c.addr_i = addr; if_c.data_i = data; if_c.w_mask_i = mask;
        @(negedge clk);
        if_c.v_i = 1'b0;
    endtask

    task automatic rd_c(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        if_c.v_i = 1'b1; if_c.w_i = 1'b0; if_c.addr_i = addr;
        @(negedge clk);
        if_c.v_i = 1'b0;
        check({tag, ".v"}, if_c.v_o, 1);
        check(tag, if_c.data_o, exp);
    endtask

    // Counts negedges from now until each ready_o is seen high; while A sweeps,
    // a read request and a stray init pulse are applied to it.
    task automatic count_ready(input string tag, input int exp_a, input int exp_b, input int exp_c);
        int  na = 0;
        int  nb = 0;
        int  nc = 0;
        bit  seen_v = 1'b0;
        for (int n = 1; n <= 2000 && na == 0; n++) begin
            @(negedge clk);
            if (if_a.ready_o && na == 0) na = n;
            if (if_b.ready_o && nb == 0) nb = n;
            if (if_c.ready_o && nc == 0) nc = n;
            if (if_a.v_o) seen_v = 1'b1;
            if (n == 10) begin
                init_a = 1'b1; if_a.v_i = 1'b1; if_a.w_i = 1'b0; if_a.addr_i = 9'd0;
            end
            if (n == 11) init_a = 1'b0;
        end
        if_a.v_i = 1'b0;
        check({tag, ".ready_a"}, na, exp_a);
        check({tag, ".ready_b"}, nb, exp_b);
        check({tag, ".ready_c"}, nc, exp_c);
        check({tag, ".no_v_in_init"}, seen_v, 0);
    endtask

    initial begin
        int n_low;
        if_a.v_i = 0; if_a.w_i = 0; if_a.addr_i = '0; if_a.data_i = '0; if_a.w_mask_i = '0;
        if_b.v_i = 0; if_b.w_i = 0; if_b.addr_i = '0; if_b.data_i = '0; if_b.w_mask_i = '0;
        if_c.v_i = 0; if_c.w_i = 0; if_c.addr_i = '0; if_c.data_i = '0; if_c.w_mask_i = '0;

        repeat (3) @(negedge clk);
        check("rst.ready_a", if_a.ready_o, 0);
        check("rst.v_a",     if_a.v_o, 0);
        check("rst.data_a",  if_a.data_o, 0);
        check("rst.ready_b", if_b.ready_o, 0);
        check("rst.ready_c", if_c.ready_o, 0);

        rst_n = 1'b1;
        count_ready("por", 513, 96, 1);

        // Geometry A: 64b x 512, byte mask, init 0
        rd_a("a.rd0",   9'd0,   64'h0);
        rd_a("a.rd255", 9'd255, 64'h0);
        rd_a("a.rd511", 9'd511, 64'h0);
        wr_a(9'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr_a(9'd3, 64'h0, 8'b0000_0101);
        rd_a("a.bytemask", 9'd3, 64'hFFFF_FFFF_FF00_FF00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a.hold_v", if_a.v_o, 0);
            check("a.hold_data", if_a.data_o, 64'hFFFF_FFFF_FF00_FF00);
        end
        wr_a(9'd7, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd_a("a.raw", 9'd7, 64'h0123_4567_89AB_CDEF);
        wr_a(9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80);
        rd_a("a.b2b_0", 9'd7, 64'hFF23_4567_89AB_CDEF);
        rd_a("a.b2b_1", 9'd3, 64'hFFFF_FFFF_FF00_FF00);

        // Read one cycle before init_i, then init_i with a colliding write
        if_a.v_i = 1'b1; if_a.w_i = 1'b0; if_a.addr_i = 9'd7;
        @(negedge clk);
        check("a.rd_pre_init", if_a.data_o, 64'hFF23_4567_89AB_CDEF);
        check("a.rd_pre_init.v", if_a.v_o, 1);
        init_a = 1'b1; if_a.w_i = 1'b1; if_a.addr_i = 9'd10; if_a.data_i = 64'hDEAD_BEEF; if_a.w_mask_i = 8'hFF;
        @(negedge clk);
        init_a = 1'b0; if_a.v_i = 1'b0;
        check("a.init_ready_low", if_a.ready_o, 0);
        check("a.init_no_v", if_a.v_o, 0);
        n_low = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (if_a.ready_o) begin
                n_low = n;
                break;
            end
        end
        check("a.init_len", n_low, 512);
        rd_a("a.post_init10", 9'd10, 64'h0);
        rd_a("a.post_init3",  9'd3,  64'h0);
        rd_a("a.post_init7",  9'd7,  64'h0);

        // Geometry B: 96b x 95, bit mask, non-zero init value
        rd_b("b.rd0",  7'd0,  c_init_b);
        rd_b("b.rd94", 7'd94, c_init_b);
        wr_b(7'd94, '1, '1);
        rd_b("b.full", 7'd94, {96{1'b1}});
        wr_b(7'd94, '0, 96'hF);
        rd_b("b.bitmask_lo", 7'd94, {{92{1'b1}}, 4'h0});
        wr_b(7'd94, '0, 96'h8000_0000_0000_0000_0000_0001);
        rd_b("b.bitmask_ends", 7'd94, 96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFF0);
        wr_b(7'd100, '0, '1);
        rd_b("b.oor", 7'd100, 96'h0);
        rd_b("b.intact94", 7'd94, 96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFF0);

        // Geometry C: 16b x 8, no mask, no init
        wr_c(3'd5, 16'hBEEF, 1'b0);
        rd_c("c.nomask0", 3'd5, 16'hBEEF);
        wr_c(3'd5, 16'h1234, 1'b1);
        wr_c(3'd6, 16'hA5A5, 1'b0);
        rd_c("c.nomask1", 3'd5, 16'h1234);
        rd_c("c.nomask2", 3'd6, 16'hA5A5);

        // Reset in the middle of an init sweep on A
        wr_a(9'd20, 64'h1234, 8'hFF);
        rd_a("a.pre_rst", 9'd20, 64'h1234);
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        check("a.hold_in_init", if_a.data_o, 64'h1234);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid.ready_a", if_a.ready_o, 0);
        check("mid.v_a",     if_a.v_o, 0);
        check("mid.data_a",  if_a.data_o, 0);
        check("mid.data_c",  if_c.data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_ready("rerun", 513, 96, 1);
        rd_a("a.after_rerun20", 9'd20, 64'h0);
        rd_b("b.after_rerun94", 7'd94, c_init_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_hard_mem_1rw_init_wrapper.md
# bp_hard_mem_1rw_init_wrapper

Parametrised single-port (1RW) hard-memory wrapper for BlackParrot caches and tag/state arrays; supersedes the per-geometry fixed wrappers with one module covering any width/depth and three write-mask modes. Adds a hardware initialisation sweep after reset or on request, a read-valid strobe and a read-data hold register. Sits between bp cache engines and `la_spram`.

## Interface
- `width_p`, 64: data width in bits.
- `els_p`, 512: number of words (need not be a power of two).
- `mask_mode_p`, 0: 0 = no mask, full-word write; 1 = bit mask; 2 = byte mask (`width_p % 8 == 0` required).
- `init_en_p`, 1: 1 = run the init sweep after reset; 0 = ready immediately after reset.
- `init_val_p`, '0: word written to every address during the sweep.
- Derived: `addr_width_lp = $clog2(els_p)` (minimum 1); `mask_width_lp` = 1, `width_p` or `width_p/8` for modes 0/1/2.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `init_i`  in  1  single-cycle pulse; re-runs the init sweep.
- `v_i`  in  1  access request.
- `w_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  addr_width_lp  word address.
- `data_i`  in  width_p  write data.
- `w_mask_i`  in  mask_width_lp  write mask, 1 = write bit/byte; ignored in mode 0.
- `ready_o`  out  1  accepting requests.
- `v_o`  out  1  read data valid, one-cycle pulse.
- `data_o`  out  width_p  read data, held until the next read.

## Operation
- FSM states: RESET, INIT, READY.
- RESET: entered asynchronously while `reset_n_i`=0. Outputs forced: `ready_o`=0, `v_o`=0, `data_o`=0, init counter=0.
- On deassertion of reset: go to INIT if `init_en_p`=1, else to READY.
- INIT: each cycle writes `init_val_p` with full mask to address = counter, then increments the counter.
  - After writing address `els_p-1`: counter clears and the FSM enters READY.
  - `v_i` is ignored in INIT: no write, no `v_o`.
- READY: `ready_o`=1. An access is accepted when `v_i & ready_o`.
- Accepted write: the mask is expanded to a width_p-bit mask.
  - Mode 0: all ones.
  - Mode 1: used as is.
  - Mode 2: byte k is replicated to bits [8k+7:8k].
  - The write drives `la_spram` with `ce=1`, `we=1` and the expanded mask. `v_o` is not asserted.
- Accepted read: `ce=1`, `we=0`. `v_o`=1 on the next cycle, with `data_o` = memory word.
- Hold register: on every `v_o` cycle, it captures the read data. When `v_o`=0, `data_o` shows the hold register, so the output stays stable until the next read.
- Out-of-range address (`addr_i >= els_p`, possible only for non-power-of-two depths):
  - write: suppressed (`ce=0`);
  - read: `v_o` still pulses, `data_o` = 0.
- `init_i` in READY: go to INIT next cycle. If `v_i` is high in the same cycle, `init_i` wins and the request is dropped.
- `init_i` during INIT: ignored; the sweep continues without restarting.
- Reset asserted mid-INIT: the sweep aborts. It restarts from address 0 after deassertion; memory contents are undefined until it completes.
- `la_spram` is idle (`ce=0`) whenever no write/read/init activity is in progress.

## Timing
- Read latency: 1 cycle from acceptance to `v_o`. Back-to-back reads every cycle produce back-to-back `v_o` pulses.
- Write: the word is visible to a read accepted on the following cycle.
- Read-after-write to the same address on consecutive cycles returns the new data.
- INIT duration: exactly `els_p` cycles.
  - After reset: `ready_o` rises `els_p` cycles after the first clock edge with `reset_n_i`=1.
  - After `init_i`: `ready_o` falls the cycle after the pulse and rises `els_p` cycles later.
- A read accepted in the same cycle as `init_i` never happens (the request is dropped). A read accepted the cycle before `init_i` still produces its `v_o`.
- All outputs are registered or derived from FSM/registered state. No combinational path from any input to `ready_o`.

## Structure
- Package `bp_hard_mem_pkg`: mask-mode constants (`e_mask_none`, `e_mask_bit`, `e_mask_byte`) and the FSM state enum.
- One sub-module, `bp_hard_mem_mask_expand`: purely combinational, converts the mode-specific mask to a width_p-bit mask.
- Top level contains:
  - the FSM and init counter;
  - the address range check;
  - the read-valid and out-of-range flag registers;
  - the hold register;
  - one `la_spram #(.DW(width_p), .AW(addr_width_lp))` instance, with `ctrl`/`test`/supply ports tied off.

## Test plan
- Reset, `width_p`=64, `els_p`=512, `init_val_p`=0: `ready_o` rises after exactly 512 cycles; reads of addresses 0, 255 and 511 return 0 with `v_o` one cycle after acceptance.
- Mode 2 byte mask: write 0xFFFF_FFFF_FFFF_FFFF to address 3, then write 0x0 with mask 8'b0000_0101. Read returns 0xFFFF_FFFF_FF00_FF00; `data_o` holds that value for 10 idle cycles.
- Mode 1, `width_p`=96, bit mask 0x…0F: only bits [3:0] change; the other bits keep their prior value.
- `els_p`=95 (AW=7): write to address 100 is dropped; a read of 100 gives `v_o`=1 with `data_o`=0, and address 94 is intact.
- `init_i` with simultaneous `v_i` write: the write is lost; `ready_o`=0 for `els_p` cycles; all addresses equal `init_val_p` afterwards.
- Reset asserted at INIT cycle 100: outputs 0 immediately; after release the sweep takes the full `els_p` cycles, and `v_i` during INIT yields no `v_o`.
